memreq_splitter: RTL and testbench
==================================

# memreq_splitter

Splits core memory requests that cross an 8-byte boundary into two non-crossing beats, and merges the read data from both beats back into one response. Sits between the core load/store port and the memory request aligner. Every beat it emits stays inside one 8-byte word: the address keeps its in-word byte offset, the write data is unshifted, and the strobe is already in byte-lane position. The aligner then moves the data to and from the lanes.

## Interface
- `AddrSize`, default 32: address width.
- `DataSize`, default 64: data width. Fixed at 8 bytes.
- `AlignmentBytes`, default 8: word size in bytes.
- `clk_i`  in  1: clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `core_req_i`  in  1: request valid. Held until `core_gnt_o`.
- `core_gnt_o`  out  1: request accepted. Pulses with the final downstream grant.
- `core_addr_i`  in  AddrSize: byte address. Any alignment.
- `core_wdata_i`  in  DataSize: write data, LSB-justified.
- `core_size_i`  in  2: access size. 0=1B, 1=2B, 2=4B, 3=8B.
- `core_we_i`  in  1: write enable.
- `core_rdata_o`  out  DataSize: read data, LSB-justified. Bytes above the access size are 0.
- `core_rvalid_o`  out  1: read data valid.
- `mem_req_o`  out  1: beat request.
- `mem_gnt_i`  in  1: beat grant.
- `mem_addr_o`  out  AddrSize: beat address.
- `mem_wdata_o`  out  DataSize: beat write data, unshifted.
- `mem_strb_o`  out  8: byte-lane strobe.
- `mem_we_o`  out  1: write enable.
- `mem_rdata_i`  in  DataSize: read data from the aligner, already shifted right by the beat offset.

## Operation
- Beat geometry:
  - off = addr[2:0]; n = 1<<size.
  - A request crosses when off+n > 8.
  - m = (1<<n)-1, computed 9 bits wide.
- Beat 0:
  - addr = core_addr.
  - wdata = core_wdata.
  - strb = (m<<off)[7:0].
  - Valid low read bytes: min(n, 8-off).
- Beat 1 (crossing requests only):
  - addr = (core_addr & ~7)+8, modulo 2^AddrSize.
  - wdata = core_wdata >> 8*(8-off).
  - strb = m >> (8-off).
- Read merge:
  - Beat-0 data is masked to its 8-off bytes.
  - Result = beat0_low | (beat1 << 8*(8-off)).
  - The result is masked to n bytes.
- FSM states:
  - IDLE:
    - All `mem_*` outputs are combinational from the `core_*` inputs; `mem_req_o` = `core_req_i`.
    - Non-crossing request with `mem_gnt_i`: assert `core_gnt_o`, stay in IDLE.
    - Crossing request with `mem_gnt_i`: latch addr, wdata, size, we and off; go to SECOND. `core_gnt_o` stays 0.
  - SECOND:
    - `mem_req_o`=1 and beat-1 fields are driven from the latched copy. `core_*` inputs are ignored.
    - On `mem_gnt_i`: assert `core_gnt_o`, return to IDLE.
- Beat-0 read data of a crossing read is captured into a holding register in the cycle after its grant.
- `core_rvalid_o` is asserted only for reads. Writes produce no response.
- A new core request may be issued in the same cycle that `core_rvalid_o` is high.

## Timing
- Reset values:
  - state IDLE.
  - `core_rvalid_o`=0, `core_rdata_o`=0.
  - Holding register = 0.
  - While `rst_i` is high, `mem_req_o` and `core_gnt_o` are forced to 0.
- Downstream read data is valid exactly one cycle after its grant.
- Non-crossing access:
  - Zero added cycles on the request path.
  - `core_rvalid_o` is high one cycle after the grant.
  - `core_rdata_o` is combinational from `mem_rdata_i` and masked.
- Crossing access:
  - Minimum two grant cycles.
  - `core_rvalid_o` is high one cycle after the beat-1 grant.
  - `core_rdata_o` merges the holding register with the current `mem_rdata_i`.
- Grant stalls: every `mem_*` output is held stable while `mem_req_o`=1 and `mem_gnt_i`=0.
- Reset during SECOND or a pending response:
  - Asynchronous return to IDLE.
  - `mem_req_o` drops in the same cycle.
  - No `core_rvalid_o` follows.
- The FSM has no error states. Every size/offset combination is legal.

## Structure
- Shared package `memreq_pkg`:
  - `size_e` enum.
  - `AlignmentBytes`, `LOG2_AlignmentBytes`.
  - `addr_t`, `data_t`, `strb_t`.
  - Function `size_to_mask`.
- One combinational sub-module `memreq_beat_calc`:
  - Inputs: addr, size, wdata.
  - Outputs: crossing flag, both beat addrs, strobes, wdata, off.
  - Reused for the read-merge shift amounts.
- Top level holds the FSM, the request latch and the response registers.

## Test plan
- Aligned 4B read at 0x1000 with `mem_gnt_i`=1:
  - One beat: addr 0x1000, strb 0x0F, `core_gnt_o` in the same cycle.
  - Next cycle: `core_rvalid_o`=1, `core_rdata_o` = low 4 bytes of `mem_rdata_i`.
- 4B write at 0x1006, wdata 0xAABBCCDD:
  - Beat 0: addr 0x1006, strb 0xC0, wdata 0xAABBCCDD.
  - Beat 1: addr 0x1008, strb 0x03, wdata 0xAABB.
  - `core_gnt_o` only with beat 1. No rvalid.
- 8B read at 0x2003:
  - Beat 0: addr 0x2003, strb 0xF8. Aligner returns 0x0000007766554433.
  - Beat 1: addr 0x2008, strb 0x07. Aligner returns 0xFFEEDDCCBBAA9988.
  - Result: `core_rdata_o`=0xAA99887766554433, one cycle after the beat-1 grant.
- `mem_gnt_i` held low for 3 cycles in SECOND:
  - `mem_req_o`=1 with addr, strb and wdata stable.
  - `core_gnt_o`=0 until the grant arrives.
- `rst_i` pulsed in SECOND:
  - `mem_req_o`=0 in the same cycle. No `core_rvalid_o`.
  - The next request starts at beat 0.
- 2B read at 0xFFFFFFFF:
  - Beat 0 strb 0x80.
  - Beat 1 addr 0x00000000, strb 0x01.
  - Merged 2-byte result, with upper bytes 0.

Source files
------------

// File: rtl/memreq_pkg.sv
// Shared types and helpers for the memory request splitter.
// Size encoding, word geometry, and byte/bit mask helpers.
package memreq_pkg;

    localparam int unsigned AlignmentBytes      = 8;
    localparam int unsigned LOG2_AlignmentBytes = 3;

    typedef enum logic [1:0] {
        SIZE_1B = 2'd0,
        SIZE_2B = 2'd1,
        SIZE_4B = 2'd2,
        SIZE_8B = 2'd3
    } size_e;

    typedef logic [31:0] addr_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  strb_t;

    // Byte mask of an access of 1<<size bytes; 9 bits so the 8-byte case does not wrap.
    function automatic logic [8:0] size_to_mask(input logic [1:0] size);
        logic [3:0] n;
        n = 4'd1 << size;
        return (9'd1 << n) - 9'd1;
    endfunction

    // Bit distance from a word offset to the next word boundary.
    function automatic logic [6:0] split_shift(input logic [2:0] off);
        return {4'd8 - {1'b0, off}, 3'b000};
    endfunction

    function automatic data_t size_to_bitmask(input size_e size);
        case (size)
            SIZE_1B: return 64'h0000_0000_0000_00FF;
            SIZE_2B: return 64'h0000_0000_0000_FFFF;
            SIZE_4B: return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/memreq_beat_calc.sv
// Combinational beat geometry: crossing flag plus address, strobe and
// write data for both beats of a request.
module memreq_beat_calc #(
    parameter int unsigned AddrSize       = 32,
    parameter int unsigned DataSize       = 64,
    parameter int unsigned AlignmentBytes = 8
) (
    input  logic [AddrSize-1:0] i_addr,
    input  logic [1:0]          i_size,
    input  logic [DataSize-1:0] i_wdata,
    output logic                o_cross,
    output logic [AddrSize-1:0] o_addr0,
    output logic [AddrSize-1:0] o_addr1,
    output logic [7:0]          o_strb0,
    output logic [7:0]          o_strb1,
    output logic [DataSize-1:0] o_wdata0,
    output logic [DataSize-1:0] o_wdata1,
    output logic [2:0]          o_off,
    output logic [6:0]          o_split_sh
);
    import memreq_pkg::*;

    logic [2:0]  w_off;
    logic [3:0]  w_nbytes;
    logic [8:0]  w_mask;
    logic [15:0] w_strb_wide;

    assign w_off       = i_addr[LOG2_AlignmentBytes-1:0];
    assign w_nbytes    = 4'd1 << i_size;
    assign w_mask      = size_to_mask(i_size);
    // Upper byte of the shifted mask equals m >> (8-off): the beat-1 strobe.
    assign w_strb_wide = {7'b0, w_mask} << w_off;

    assign o_off      = w_off;
    assign o_split_sh = split_shift(w_off);
    assign o_cross    = ({2'b00, w_off} + {1'b0, w_nbytes}) > 5'd8;
    assign o_addr0    = i_addr;
    assign o_addr1    = (i_addr & ~AddrSize'(AlignmentBytes - 1)) + AddrSize'(AlignmentBytes);
    assign o_strb0    = w_strb_wide[7:0];
    assign o_strb1    = w_strb_wide[15:8];
    assign o_wdata0   = i_wdata;
    assign o_wdata1   = i_wdata >> o_split_sh;

endmodule

// File: rtl/memreq_splitter.sv
// Splits word-crossing core requests into two beats and merges the read
// data of both beats into a single LSB-justified response.
module memreq_splitter #(
    parameter int unsigned AddrSize       = 32,
    parameter int unsigned DataSize       = 64,
    parameter int unsigned AlignmentBytes = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                core_req_i,
    output logic                core_gnt_o,
    input  logic [AddrSize-1:0] core_addr_i,
    input  logic [DataSize-1:0] core_wdata_i,
    input  logic [1:0]          core_size_i,
    input  logic                core_we_i,
    output logic [DataSize-1:0] core_rdata_o,
    output logic                core_rvalid_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [AddrSize-1:0] mem_addr_o,
    output logic [DataSize-1:0] mem_wdata_o,
    output logic [7:0]          mem_strb_o,
    output logic                mem_we_o,
    input  logic [DataSize-1:0] mem_rdata_i
);
    import memreq_pkg::*;

    typedef enum logic {ST_IDLE, ST_SECOND} state_e;

    state_e              r_state;
    logic [AddrSize-1:0] r_addr;
    logic [DataSize-1:0] r_wdata;
    logic [DataSize-1:0] r_hold;
    size_e               r_size;
    size_e               r_rsp_size;
    logic                r_we;
    logic [2:0]          r_off;
    logic [2:0]          r_rsp_off;
    logic                r_cap;
    logic                r_rvalid;
    logic                r_rsp_cross;

    logic                w_second;
    logic [AddrSize-1:0] w_calc_addr;
    logic [1:0]          w_calc_size;
    logic [DataSize-1:0] w_calc_wdata;
    logic                w_cross;
    logic [AddrSize-1:0] w_addr0;
    logic [AddrSize-1:0] w_addr1;
    strb_t               w_strb0;
    strb_t               w_strb1;
    logic [DataSize-1:0] w_wdata0;
    logic [DataSize-1:0] w_wdata1;
    logic [2:0]          w_off;
    logic [6:0]          w_calc_sh;
    logic [6:0]          w_rsp_sh;
    logic [DataSize-1:0] w_merged;

    assign w_second = (r_state == ST_SECOND);

    // One calculator serves both beats: core inputs in IDLE, latched copy in SECOND.
    assign w_calc_addr  = w_second ? r_addr  : core_addr_i;
    assign w_calc_size  = w_second ? r_size  : core_size_i;
    assign w_calc_wdata = w_second ? r_wdata : core_wdata_i;

    memreq_beat_calc #(
        .AddrSize       (AddrSize),
        .DataSize       (DataSize),
        .AlignmentBytes (AlignmentBytes)
    ) u_calc (
        .i_addr     (w_calc_addr),
        .i_size     (w_calc_size),
        .i_wdata    (w_calc_wdata),
        .o_cross    (w_cross),
        .o_addr0    (w_addr0),
        .o_addr1    (w_addr1),
        .o_strb0    (w_strb0),
        .o_strb1    (w_strb1),
        .o_wdata0   (w_wdata0),
        .o_wdata1   (w_wdata1),
        .o_off      (w_off),
        .o_split_sh (w_calc_sh)
    );

    assign mem_req_o   = !rst_i && (w_second || core_req_i);
    assign mem_addr_o  = w_second ? w_addr1  : w_addr0;
    assign mem_strb_o  = w_second ? w_strb1  : w_strb0;
    assign mem_wdata_o = w_second ? w_wdata1 : w_wdata0;
    assign mem_we_o    = w_second ? r_we     : core_we_i;
    assign core_gnt_o  = !rst_i && mem_gnt_i &&
                         (w_second || (core_req_i && !w_cross));

    assign w_rsp_sh      = split_shift(r_rsp_off);
    assign w_merged      = r_rsp_cross ? (r_hold | (mem_rdata_i << w_rsp_sh)) : mem_rdata_i;
    assign core_rdata_o  = r_rvalid ? (w_merged & size_to_bitmask(r_rsp_size)) : '0;
    assign core_rvalid_o = r_rvalid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_hold      <= '0;
            r_size      <= SIZE_1B;
            r_rsp_size  <= SIZE_1B;
            r_we        <= 1'b0;
            r_off       <= '0;
            r_rsp_off   <= '0;
            r_cap       <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rsp_cross <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_cap    <= 1'b0;
            // Beat-0 data arrives in the first SECOND cycle; keep only its 8-off bytes.
            if (r_cap) begin
                r_hold <= mem_rdata_i & ~({DataSize{1'b1}} << w_calc_sh);
            end
            case (r_state)
                ST_IDLE: begin
                    if (core_req_i && mem_gnt_i) begin
                        if (w_cross) begin
                            r_addr  <= core_addr_i;
                            r_wdata <= core_wdata_i;
                            r_size  <= size_e'(core_size_i);
                            r_we    <= core_we_i;
                            r_off   <= w_off;
                            r_cap   <= !core_we_i;
                            r_state <= ST_SECOND;
                        end else begin
                            r_rvalid    <= !core_we_i;
                            r_rsp_cross <= 1'b0;
                            r_rsp_size  <= size_e'(core_size_i);
                            r_rsp_off   <= w_off;
                        end
                    end
                end
                ST_SECOND: begin
                    if (mem_gnt_i) begin
                        r_rvalid    <= !r_we;
                        r_rsp_cross <= 1'b1;
                        r_rsp_size  <= r_size;
                        r_rsp_off   <= r_off;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memreq_splitter.sv
// Directed bench for memreq_splitter: inputs change on the falling edge,
// outputs are checked 1ns later against hand-computed values.
module tb_memreq_splitter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_gnt_o;
    logic [31:0] core_addr_i;
    logic [63:0] core_wdata_i;
    logic [1:0]  core_size_i;
    logic        core_we_i;
    logic [63:0] core_rdata_o;
    logic        core_rvalid_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_strb_o;
    logic        mem_we_o;
    logic [63:0] mem_rdata_i;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    memreq_splitter #(
        .AddrSize       (32),
        .DataSize       (64),
        .AlignmentBytes (8)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_req_i    (core_req_i),
        .core_gnt_o    (core_gnt_o),
        .core_addr_i   (core_addr_i),
        .core_wdata_i  (core_wdata_i),
        .core_size_i   (core_size_i),
        .core_we_i     (core_we_i),
        .core_rdata_o  (core_rdata_o),
        .core_rvalid_o (core_rvalid_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_strb_o    (mem_strb_o),
        .mem_we_o      (mem_we_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic [1:0] size,
                         input logic we, input logic [63:0] wdata, input logic gnt,
                         input logic [63:0] rdata);
        core_req_i   = req;
        core_addr_i  = addr;
        core_size_i  = size;
        core_we_i    = we;
        core_wdata_i = wdata;
        mem_gnt_i    = gnt;
        mem_rdata_i  = rdata;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b1, 32'h0000_1000, 2'd2, 1'b0, 64'h0, 1'b1, 64'h0);
        #2;
        check_val("rst_mem_req", mem_req_o, 1'b0);
        check_val("rst_core_gnt", core_gnt_o, 1'b0);
        check_val("rst_rvalid", core_rvalid_o, 1'b0);
        check_val("rst_rdata", core_rdata_o, 64'h0);

        // Aligned 4B read at 0x1000
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b1, 32'h0000_1000, 2'd2, 1'b0, 64'h0, 1'b1, 64'h0);
        #1;
        check_val("rd4_req", mem_req_o, 1'b1);
        check_val("rd4_addr", mem_addr_o, 32'h0000_1000);
        check_val("rd4_strb", mem_strb_o, 8'h0F);
        check_val("rd4_gnt", core_gnt_o, 1'b1);
        check_val("rd4_we", mem_we_o, 1'b0);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 2'd0, 1'b0, 64'h0, 1'b0, 64'h1122_3344_5566_7788);
        #1;
        check_val("rd4_rvalid", core_rvalid_o, 1'b1);
        check_val("rd4_rdata", core_rdata_o, 64'h0000_0000_5566_7788);
        check_val("idle_req", mem_req_o, 1'b0);

        // Crossing 4B write at 0x1006
        @(negedge clk_i);
        drive(1'b1, 32'h0000_1006, 2'd2, 1'b1, 64'hAABB_CCDD, 1'b1, 64'h0);
        #1;
        check_val("wr_b0_addr", mem_addr_o, 32'h0000_1006);
        check_val("wr_b0_strb", mem_strb_o, 8'hC0);
        check_val("wr_b0_wdata", mem_wdata_o, 64'hAABB_CCDD);
        check_val("wr_b0_we", mem_we_o, 1'b1);
        check_val("wr_b0_gnt", core_gnt_o, 1'b0);
        check_val("wr_b0_rvalid", core_rvalid_o, 1'b0);
        @(negedge clk_i);
        // Core inputs are scrambled here: SECOND must ignore them.
        drive(1'b1, 32'h0000_5555, 2'd0, 1'b0, 64'h1234, 1'b1, 64'h0);
        #1;
        check_val("wr_b1_req", mem_req_o, 1'b1);
        check_val("wr_b1_addr", mem_addr_o, 32'h0000_1008);
        check_val("wr_b1_strb", mem_strb_o, 8'h03);
        check_val("wr_b1_wdata", mem_wdata_o, 64'hAABB);
        check_val("wr_b1_we", mem_we_o, 1'b1);
        check_val("wr_b1_gnt", core_gnt_o, 1'b1);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 2'd0, 1'b0, 64'h0, 1'b0, 64'h0);
        #1;
        check_val("wr_no_rvalid", core_rvalid_o, 1'b0);

        // Crossing 8B read at 0x2003 with a 3-cycle stall on beat 1
        @(negedge clk_i);
        drive(1'b1, 32'h0000_2003, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0);
        #1;
        check_val("rd8_b0_addr", mem_addr_o, 32'h0000_2003);
        check_val("rd8_b0_strb", mem_strb_o, 8'hF8);
        check_val("rd8_b0_gnt", core_gnt_o, 1'b0);
        @(negedge clk_i);
        mem_gnt_i   = 1'b0;
        mem_rdata_i = 64'h0000_0077_6655_4433;
        #1;
        for (int unsigned i = 0; i < 3; i++) begin
            check_val("stall_req", mem_req_o, 1'b1);
            check_val("stall_addr", mem_addr_o, 32'h0000_2008);
            check_val("stall_strb", mem_strb_o, 8'h07);
            check_val("stall_wdata", mem_wdata_o, 64'h0000_0000_0001_2345);
            check_val("stall_gnt", core_gnt_o, 1'b0);
            check_val("stall_rvalid", core_rvalid_o, 1'b0);
            @(negedge clk_i);
            mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
            #1;
        end
        mem_gnt_i = 1'b1;
        #1;
        check_val("rd8_b1_gnt", core_gnt_o, 1'b1);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 2'd0, 1'b0, 64'h0, 1'b0, 64'hFFEE_DDCC_BBAA_9988);
        #1;
        check_val("rd8_rvalid", core_rvalid_o, 1'b1);
        check_val("rd8_rdata", core_rdata_o, 64'hAA99_8877_6655_4433);

        // Reset pulsed while in SECOND
        @(negedge clk_i);
        drive(1'b1, 32'h0000_3005, 2'd2, 1'b0, 64'h0, 1'b1, 64'h0);
        #1;
        check_val("rs_b0_gnt", core_gnt_o, 1'b0);
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        #1;
        check_val("rs_b1_addr", mem_addr_o, 32'h0000_3008);
        #1;
        rst_i = 1'b1;
        #1;
        check_val("rs_mem_req", mem_req_o, 1'b0);
        check_val("rs_core_gnt", core_gnt_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_val("rs_rvalid", core_rvalid_o, 1'b0);
        check_val("rs_restart_req", mem_req_o, 1'b1);
        check_val("rs_restart_addr", mem_addr_o, 32'h0000_3005);
        check_val("rs_restart_strb", mem_strb_o, 8'hE0);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 2'd0, 1'b0, 64'h0, 1'b0, 64'h0);
        #1;
        check_val("rs_no_rvalid", core_rvalid_o, 1'b0);

        // 2B read at 0xFFFFFFFF wrapping to address 0
        @(negedge clk_i);
        drive(1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0, 64'h0, 1'b1, 64'h0);
        #1;
        check_val("wrap_b0_addr", mem_addr_o, 32'hFFFF_FFFF);
        check_val("wrap_b0_strb", mem_strb_o, 8'h80);
        check_val("wrap_b0_gnt", core_gnt_o, 1'b0);
        @(negedge clk_i);
        mem_rdata_i = 64'hFFFF_FFFF_FFFF_FF5A;
        #1;
        check_val("wrap_b1_addr", mem_addr_o, 32'h0000_0000);
        check_val("wrap_b1_strb", mem_strb_o, 8'h01);
        check_val("wrap_b1_gnt", core_gnt_o, 1'b1);
        // New 1B read issued in the same cycle as the merged response
        @(negedge clk_i);
        drive(1'b1, 32'h0000_4002, 2'd0, 1'b0, 64'h0, 1'b1, 64'h1234_5678_9ABC_DEC3);
        #1;
        check_val("wrap_rvalid", core_rvalid_o, 1'b1);
        check_val("wrap_rdata", core_rdata_o, 64'h0000_0000_0000_C35A);
        check_val("b2b_addr", mem_addr_o, 32'h0000_4002);
        check_val("b2b_strb", mem_strb_o, 8'h04);
        check_val("b2b_gnt", core_gnt_o, 1'b1);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 2'd0, 1'b0, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FF77);
        #1;
        check_val("b2b_rvalid", core_rvalid_o, 1'b1);
        check_val("b2b_rdata", core_rdata_o, 64'h77);
        @(negedge clk_i);
        #1;
        check_val("end_rvalid", core_rvalid_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
